// File: rtl/axi_pkg.sv
// Shared definitions for the AXI-style TX and RX channel blocks.
// Holds the default channel geometry plus pointer and data types for that geometry.
package axi_pkg;

    localparam int TX_WIDTH   = 8;
    localparam int TX_DEPTH   = 4;
    localparam int TX_TIMEOUT = 16;

    // Address width of a DEPTH-entry store; a 1-entry store still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AW = addr_w(TX_DEPTH);

    typedef logic [AW:0]         ptr_t;
    typedef logic [TX_WIDTH-1:0] data_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// Storage for the TX channel FIFO: DEPTH x WIDTH words.
// Synchronous write port and combinational read port; the array is never reset.
module tx_fifo_mem
    import axi_pkg::*;
#(
    parameter int WIDTH = TX_WIDTH,
    parameter int DEPTH = TX_DEPTH,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             ACLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge ACLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_tx_channel.sv
// Transmit side of a VALID/READY channel fed by a DEPTH-entry FIFO.
// Optional stall watchdog on tx_timeout is built only when AXI_TX_TIMEOUT_EN is defined.
module axi_tx_channel
    import axi_pkg::*;
#(
    parameter int WIDTH   = TX_WIDTH,
    parameter int DEPTH   = TX_DEPTH,
    parameter int TIMEOUT = TX_TIMEOUT
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    output logic                     VALID,
    input  logic                     READY,
    output logic [WIDTH-1:0]         xDATA,
    input  logic [WIDTH-1:0]         tx_data,
    input  logic                     tx_push,
    output logic                     tx_full,
    output logic                     tx_empty,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_timeout
);

    localparam int PAW = addr_w(DEPTH);
    localparam logic [PAW:0] PTR_ONE = 1;

    logic [PAW:0]     wr_ptr;
    logic [PAW:0]     rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] head;

    // Flags and VALID come only from the registered pointers, never from inputs.
    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_full  = (wr_ptr[PAW] != rd_ptr[PAW]) && (wr_ptr[PAW-1:0] == rd_ptr[PAW-1:0]);
    assign tx_count = wr_ptr - rd_ptr;
    assign VALID    = !tx_empty;
    assign xDATA    = VALID ? head : '0;

    assign push_ok = tx_push && !tx_full;
    assign pop_ok  = VALID && READY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    tx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PAW)
    ) u_mem (
        .ACLK  (ACLK),
        .we    (push_ok),
        .waddr (wr_ptr[PAW-1:0]),
        .wdata (tx_data),
        .raddr (rd_ptr[PAW-1:0]),
        .rdata (head)
    );

`ifdef AXI_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT - 1);

    logic [CW-1:0] stall_cnt;
    logic          stall;

    assign stall = VALID && !READY;

    // Flag rises on the edge the counter reaches TIMEOUT and holds until a handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stall_cnt  <= '0;
            tx_timeout <= 1'b0;
        end else begin
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (pop_ok) begin
                tx_timeout <= 1'b0;
            end else if (stall && stall_cnt == CNT_PRE) begin
                tx_timeout <= 1'b1;
            end
        end
    end
`else
    assign tx_timeout = 1'b0;
`endif

endmodule
